deadlock_idx0_monitor: RTL and testbench

- Simulation-side deadlock detector for one dataflow kernel (index 0).
- Samples the idle and block status of every dataflow process, plus the AXI-Stream port stall status.
- Asserts a sticky `block` flag when all processes are idle-or-blocked, at least one is blocked, and no external AXIS stall explains the stall, for STALL_CYCLES consecutive cycles.
- Instantiated by the kernel monitor top; feeds its deadlock trigger.

---
 rtl/deadlock_mon_pkg.sv | 21 ++
 rtl/deadlock_axis_qual.sv | 18 +
 rtl/deadlock_idx0_monitor.sv | 67 ++++++
 tb/tb_deadlock_idx0_monitor.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/deadlock_mon_pkg.sv
// Shared definitions for the dataflow deadlock monitors.
//   STALL_CYCLES_DEFAULT : consecutive candidate cycles before deadlock is flagged.
//   owner_idle_idx(k)    : idle-vector bit holding the idle of the process owning AXIS port k.
//   sub_idle_idx(k)      : idle-vector bit holding the idle of that process's pipeline sub-instance.
// Idle vector layout: [num_inst-1:0] per-process idle, [num_inst] kernel suspend,
// then one (owner, sub) pair per AXIS port.
package deadlock_mon_pkg;

  localparam int unsigned STALL_CYCLES_DEFAULT = 64;

  function automatic int unsigned owner_idle_idx(input int unsigned num_inst,
                                                 input int unsigned k);
    return num_inst + 1 + 2 * k;
  endfunction

  function automatic int unsigned sub_idle_idx(input int unsigned num_inst,
                                               input int unsigned k);
    return num_inst + 2 + 2 * k;
  endfunction

endpackage

// File: rtl/deadlock_axis_qual.sv
// Qualifies one AXI-Stream stall: it only explains a kernel stall while both the
// owning process and its pipeline sub-instance are active.
//   axis_block : port stalled (TDATA blk_n low)
//   owner_idle : owning process is idle
//   sub_idle   : owning process's pipeline sub-instance is idle
//   axis_valid : stall is a genuine external stall
module deadlock_axis_qual (
  input  logic axis_block,
  input  logic owner_idle,
  input  logic sub_idle,
  output logic axis_valid
);

  always_comb begin
    axis_valid = axis_block & ~owner_idle & ~sub_idle;
  end

endmodule

// File: rtl/deadlock_idx0_monitor.sv
// Deadlock detector for dataflow kernel 0.
// Flags a sticky deadlock once every process is idle or blocked, at least one is
// blocked, no qualified AXIS stall explains it and the kernel is not suspended,
// for STALL_CYCLES consecutive cycles.
//   clock           : rising-edge clock
//   reset           : synchronous active-high reset
//   axis_block_sigs : per-AXIS-port stall status
//   inst_idle_sigs  : idle vector (processes, suspend, AXIS owner/sub pairs)
//   inst_block_sigs : per-process blocked status
//   block           : registered, sticky deadlock flag
module deadlock_idx0_monitor
  import deadlock_mon_pkg::*;
#(
  parameter int unsigned NUM_AXIS     = 2,
  parameter int unsigned NUM_INST     = 4,
  parameter int unsigned NUM_IDLE     = NUM_INST + 1 + 2 * NUM_AXIS,
  parameter int unsigned STALL_CYCLES = STALL_CYCLES_DEFAULT,
  parameter int unsigned CNT_W        = $clog2(STALL_CYCLES + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_IDLE-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  output logic                block
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STALL_CYCLES);

  logic [NUM_AXIS-1:0] axis_valid;
  logic                cand;
  logic [CNT_W-1:0]    cnt;

  for (genvar k = 0; k < NUM_AXIS; k++) begin : g_axis
    deadlock_axis_qual u_qual (
      .axis_block (axis_block_sigs[k]),
      .owner_idle (inst_idle_sigs[owner_idle_idx(NUM_INST, k)]),
      .sub_idle   (inst_idle_sigs[sub_idle_idx(NUM_INST, k)]),
      .axis_valid (axis_valid[k])
    );
  end

  always_comb begin
    cand = (&(inst_idle_sigs[NUM_INST-1:0] | inst_block_sigs))
         & (|inst_block_sigs)
         & ~(|axis_valid)
         & ~inst_idle_sigs[NUM_INST];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      block <= 1'b0;
    end else if (!block) begin
      if (!cand) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        block <= 1'b1;
        cnt   <= CNT_SAT;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
module tb_deadlock_idx0_monitor;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] axis_block_sigs;
  logic [8:0] inst_idle_sigs;
  logic [3:0] inst_block_sigs;
  logic       block;

  int tests  = 0;
  int failed = 0;

  // idle[3:0]=1101, process 1 blocked: a valid stall candidate
  localparam logic [8:0] STALL_IDLE = 9'b0_0000_1101;
  localparam logic [3:0] STALL_BLK  = 4'b0010;

  deadlock_idx0_monitor #(
    .NUM_AXIS     (2),
    .NUM_INST     (4),
    .STALL_CYCLES (64)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
    .block           (block)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: block observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // n edges, checking block after each one
  task automatic hold(input int n, input logic exp, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, block, exp);
    end
  endtask

  task automatic drive(input logic [8:0] idle, input logic [3:0] blk, input logic [1:0] axis);
    inst_idle_sigs  = idle;
    inst_block_sigs = blk;
    axis_block_sigs = axis;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    check("reset_pulse", block, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    // reset with random inputs
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(9'($urandom), 4'($urandom), 2'($urandom));
      tick();
      check("reset_hold", block, 1'b0);
    end
    reset = 1'b0;
    drive('0, '0, '0);
    hold(200, 1'b0, "all_active_idle0");

    // basic stall: fires on the 64th edge, then sticky
    drive(STALL_IDLE, STALL_BLK, 2'b00);
    hold(63, 1'b0, "stall_before_64");
    hold(1, 1'b1, "stall_at_64");
    drive('0, '0, '0);
    hold(5, 1'b1, "sticky_after_clear");

    // one-cycle break at cycle 40 restarts the count
    pulse_reset();
    drive(STALL_IDLE, STALL_BLK, 2'b00);
    hold(40, 1'b0, "break_pre");
    drive(STALL_IDLE & 9'h1FE, STALL_BLK, 2'b00);
    hold(1, 1'b0, "break_cycle");
    drive(STALL_IDLE, STALL_BLK, 2'b00);
    hold(63, 1'b0, "break_restart_63");
    hold(1, 1'b1, "break_restart_64");

    // qualified AXIS stall on port 0 vetoes; owner idle removes the veto
    pulse_reset();
    drive(STALL_IDLE, STALL_BLK, 2'b01);
    hold(100, 1'b0, "axis0_veto");
    drive(STALL_IDLE | 9'b0_0010_0000, STALL_BLK, 2'b01);
    hold(63, 1'b0, "axis0_owner_idle_63");
    hold(1, 1'b1, "axis0_owner_idle_64");

    // port 1: sub-instance idle (bit 8) removes the veto
    pulse_reset();
    drive(STALL_IDLE, STALL_BLK, 2'b10);
    hold(100, 1'b0, "axis1_veto");
    drive(STALL_IDLE | 9'b1_0000_0000, STALL_BLK, 2'b10);
    hold(63, 1'b0, "axis1_sub_idle_63");
    hold(1, 1'b1, "axis1_sub_idle_64");

    // finished kernel: all idle, none blocked
    pulse_reset();
    drive(9'b0_0000_1111, 4'b0000, 2'b00);
    hold(100, 1'b0, "all_idle_not_deadlock");

    // suspend during a valid stall clears the count
    drive(STALL_IDLE, STALL_BLK, 2'b00);
    hold(30, 1'b0, "suspend_pre");
    drive(STALL_IDLE | 9'b0_0001_0000, STALL_BLK, 2'b00);
    hold(100, 1'b0, "suspended");
    drive(STALL_IDLE, STALL_BLK, 2'b00);
    hold(63, 1'b0, "suspend_release_63");
    hold(1, 1'b1, "suspend_release_64");

    // reset while deadlocked with the stall still present
    pulse_reset();
    hold(63, 1'b0, "post_reset_63");
    hold(1, 1'b1, "post_reset_64");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
